// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory request/acknowledge bus between the MEM stage and data memory
interface mem_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;

   modport master (
      output dmem_req,
      output dmem_we,
      output dmem_addr,
      output dmem_wdata,
      input  dmem_rdata,
      input  dmem_ack
   );

   modport slave (
      input  dmem_req,
      input  dmem_we,
      input  dmem_addr,
      input  dmem_wdata,
      output dmem_rdata,
      output dmem_ack
   );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory-access stage: variable-latency load/store handshake,
// upstream stall, misalign and bus-timeout reporting into the MEM/WB register.
module mem_stage #(
   parameter int TIMEOUT    = 16,
   parameter bit ADDR_CHECK = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      ex_alu_res,
   input  logic [31:0]      ex_store_data,
   input  logic [4:0]       ex_dest,
   input  logic             ex_mem2reg,
   input  logic             ex_memwr,
   input  logic             ex_regwr,
   output logic             mem_stall,
   mem_stage_if.master      dmem,
   output logic [31:0]      wb_result,
   output logic [4:0]       wb_dest,
   output logic             wb_regwr,
   output logic             wb_misalign,
   output logic             wb_buserr
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic [7:0] cnt;
   logic       is_mem;
   logic       misaligned;
   logic       start;

   always_comb begin
      is_mem     = ex_memwr | ex_mem2reg;
      misaligned = ADDR_CHECK && (ex_alu_res[1:0] != 2'b00);
      start      = (state == IDLE) && is_mem && !misaligned;
   end

   // Stall is combinational so the upstream registers hold the op on the very edge it issues.
   assign mem_stall = start || (state == BUSY);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         cnt             <= 8'd0;
         dmem.dmem_req   <= 1'b0;
         dmem.dmem_we    <= 1'b0;
         dmem.dmem_addr  <= 32'd0;
         dmem.dmem_wdata <= 32'd0;
         wb_result       <= 32'd0;
         wb_dest         <= 5'd0;
         wb_regwr        <= 1'b0;
         wb_misalign     <= 1'b0;
         wb_buserr       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               wb_buserr <= 1'b0;
               if (!is_mem) begin
                  wb_result   <= ex_alu_res;
                  wb_dest     <= ex_dest;
                  wb_regwr    <= ex_regwr;
                  wb_misalign <= 1'b0;
               end else if (misaligned) begin
                  wb_result   <= ex_alu_res;
                  wb_dest     <= ex_dest;
                  wb_regwr    <= 1'b0;
                  wb_misalign <= 1'b1;
               end else begin
                  // memwr dominates mem2reg, so a store is simply ex_memwr.
                  dmem.dmem_req   <= 1'b1;
                  dmem.dmem_we    <= ex_memwr;
                  dmem.dmem_addr  <= ex_alu_res;
                  dmem.dmem_wdata <= ex_store_data;
                  cnt             <= 8'd0;
                  wb_regwr        <= 1'b0;
                  wb_misalign     <= 1'b0;
                  state           <= BUSY;
               end
            end

            BUSY: begin
               if (dmem.dmem_ack) begin
                  dmem.dmem_req <= 1'b0;
                  state         <= DONE;
                  if (!dmem.dmem_we) begin
                     wb_result <= dmem.dmem_rdata;
                     wb_dest   <= ex_dest;
                     wb_regwr  <= ex_regwr;
                  end else begin
                     wb_regwr  <= 1'b0;
                  end
               end else if (cnt == TO_LAST) begin
                  dmem.dmem_req <= 1'b0;
                  wb_buserr     <= 1'b1;
                  wb_regwr      <= 1'b0;
                  state         <= DONE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end

            DONE: begin
               // EX/MEM still shows the finished op this cycle; it must not re-issue.
               wb_regwr    <= 1'b0;
               wb_misalign <= 1'b0;
               wb_buserr   <= 1'b0;
               state       <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
